// File: rtl/nv_nvdla_sdp_rdma_ig_cdt.sv
// SDP read-DMA ingress engine with credit-based flow control.
// Walks a 3-D surface (atoms x lines x surfaces), splits each line into
// bursts of at most BURST_MAX atoms, and issues each burst as a DMA read
// request with a matching context-queue entry pushed in the same cycle.
// Issue is gated by a credit counter that mirrors free latency-FIFO entries.
module nv_nvdla_sdp_rdma_ig_cdt #(
  parameter int AW        = 64,
  parameter int AM_AW     = 5,
  parameter int LAT_DEPTH = 160,
  parameter int BURST_MAX = 8
) (
  input  logic                   nvdla_core_clk,
  input  logic                   nvdla_core_rst,
  input  logic                   op_load,
  input  logic [AW-AM_AW-1:0]    reg2dp_base_addr,
  input  logic [32-AM_AW-1:0]    reg2dp_line_stride,
  input  logic [32-AM_AW-1:0]    reg2dp_surface_stride,
  input  logic [12:0]            reg2dp_width,
  input  logic [12:0]            reg2dp_height,
  input  logic [12:0]            reg2dp_surf_num,
  input  logic                   reg2dp_perf_dma_en,
  output logic                   dma_rd_req_vld,
  input  logic                   dma_rd_req_rdy,
  output logic [AW+15-1:0]       dma_rd_req_pd,
  output logic                   ig2cq_pvld,
  input  logic                   ig2cq_prdy,
  output logic [15:0]            ig2cq_pd,
  input  logic                   cdt_pop,
  output logic                   ig_done,
  output logic                   busy,
  output logic [31:0]            dp2reg_rdma_stall
);

  localparam int LW = AW - AM_AW;               // atom-address width
  localparam int SW = 32 - AM_AW;               // stride width
  localparam int CW = $clog2(LAT_DEPTH + 1);    // credit counter width

  localparam logic [CW-1:0] CDT_INIT = CW'(LAT_DEPTH);
  localparam logic [CW:0]   CDT_MAX  = (CW+1)'(LAT_DEPTH);
  localparam logic [13:0]   BM_ATOMS = 14'(BURST_MAX);
  localparam logic [14:0]   BM_M1    = 15'(BURST_MAX - 1);
  localparam logic [12:0]   BM_STEP  = 13'(BURST_MAX);

  typedef enum logic {IDLE, RUN} state_t;

  // Layer configuration captured at op_load so register writes during a
  // layer cannot disturb the walk in progress.
  typedef struct packed {
    logic [LW-1:0] base;
    logic [SW-1:0] line_stride;
    logic [SW-1:0] surf_stride;
    logic [12:0]   width;
    logic [12:0]   height;
    logic [12:0]   surf_num;
  } cfg_t;

  state_t        state_q, state_d;
  cfg_t          cfg;
  logic [12:0]   x_cnt, y_cnt, s_cnt;
  logic [LW-1:0] line_addr, surf_addr;
  logic [CW-1:0] credit_cnt;

  logic          run;
  logic          load_go;
  logic [13:0]   rem;
  logic          x_last, y_last, s_last, is_last;
  logic [14:0]   size_m1;
  logic [15:0]   atoms;
  logic          credit_ok;
  logic          fire;
  logic [LW-1:0] req_line;
  logic [LW-1:0] surf_nxt;
  logic [CW:0]   cdt_take;
  logic [CW:0]   cdt_sum;

  assign run     = (state_q == RUN);
  // op_load is only honoured between layers.
  assign load_go = op_load & ~run;

  // Chunk sizing: whatever is left in the line, capped at one burst.
  assign rem     = {1'b0, cfg.width} - {1'b0, x_cnt} + 14'd1;
  assign x_last  = (rem <= BM_ATOMS);
  assign size_m1 = x_last ? 15'(rem - 14'd1) : BM_M1;
  assign atoms   = 16'(size_m1) + 16'd1;
  assign y_last  = (y_cnt == cfg.height);
  assign s_last  = (s_cnt == cfg.surf_num);
  assign is_last = x_last & y_last & s_last;

  // Both sides must be able to accept before either sees a valid, so the
  // DMA request and the context entry always move together.
  assign credit_ok      = (32'(credit_cnt) >= 32'(atoms));
  assign dma_rd_req_vld = run & credit_ok & ig2cq_prdy;
  assign ig2cq_pvld     = run & credit_ok & dma_rd_req_rdy;
  assign fire           = dma_rd_req_vld & dma_rd_req_rdy;

  assign req_line = line_addr + LW'(x_cnt);
  assign surf_nxt = surf_addr + LW'(cfg.surf_stride);

  // Payloads derive only from state that advances on fire, so they hold
  // steady under backpressure; they read zero outside a layer.
  assign dma_rd_req_pd = run ? {size_m1, req_line, {AM_AW{1'b0}}} : '0;
  assign ig2cq_pd      = run ? {is_last, size_m1} : '0;
  assign busy          = run;

  // State register.
  always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
    if (nvdla_core_rst) state_q <= IDLE;
    else                state_q <= state_d;
  end

  // Next state: start on op_load, finish when the final chunk is accepted.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (op_load)         state_d = RUN;
      RUN:     if (fire && is_last) state_d = IDLE;
      default:                      state_d = IDLE;
    endcase
  end

  // Latch the layer configuration at layer start.
  always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
    if (nvdla_core_rst) begin
      cfg <= '0;
    end else if (load_go) begin
      cfg.base        <= reg2dp_base_addr;
      cfg.line_stride <= reg2dp_line_stride;
      cfg.surf_stride <= reg2dp_surface_stride;
      cfg.width       <= reg2dp_width;
      cfg.height      <= reg2dp_height;
      cfg.surf_num    <= reg2dp_surf_num;
    end
  end

  // Surface walker: advance x by a burst, then line, then surface. Address
  // sums wrap naturally at the atom-address width.
  always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
    if (nvdla_core_rst) begin
      x_cnt     <= '0;
      y_cnt     <= '0;
      s_cnt     <= '0;
      line_addr <= '0;
      surf_addr <= '0;
    end else if (load_go) begin
      x_cnt     <= '0;
      y_cnt     <= '0;
      s_cnt     <= '0;
      line_addr <= reg2dp_base_addr;
      surf_addr <= reg2dp_base_addr;
    end else if (fire) begin
      if (!x_last) begin
        x_cnt <= x_cnt + BM_STEP;
      end else begin
        x_cnt <= '0;
        if (!y_last) begin
          y_cnt     <= y_cnt + 13'd1;
          line_addr <= line_addr + LW'(cfg.line_stride);
        end else begin
          y_cnt     <= '0;
          s_cnt     <= s_cnt + 13'd1;
          surf_addr <= surf_nxt;
          line_addr <= surf_nxt;
        end
      end
    end
  end

  // Credits: consumed per atom on issue, returned one per cdt_pop. Not
  // touched by op_load since the previous layer may still have data in
  // flight. A return that would exceed LAT_DEPTH is clamped.
  assign cdt_take = fire ? (CW+1)'(atoms) : '0;
  assign cdt_sum  = {1'b0, credit_cnt} - cdt_take + (CW+1)'(cdt_pop);

  always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
    if (nvdla_core_rst)          credit_cnt <= CDT_INIT;
    else if (cdt_sum > CDT_MAX)  credit_cnt <= CDT_INIT;
    else                         credit_cnt <= cdt_sum[CW-1:0];
  end

  // More returns than entries ever handed out means the consumer is broken.
  cdt_overflow_a: assert property (
    @(posedge nvdla_core_clk) disable iff (nvdla_core_rst) cdt_sum <= CDT_MAX);

  // Done pulse one cycle after the final chunk is accepted.
  always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
    if (nvdla_core_rst) ig_done <= 1'b0;
    else                ig_done <= fire & is_last;
  end

  // Stall counter: cycles a request waits on the DMA port, saturating.
  always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
    if (nvdla_core_rst) begin
      dp2reg_rdma_stall <= '0;
    end else if (load_go) begin
      dp2reg_rdma_stall <= '0;
    end else if (reg2dp_perf_dma_en && dma_rd_req_vld && !dma_rd_req_rdy &&
                 dp2reg_rdma_stall != 32'hFFFF_FFFF) begin
      dp2reg_rdma_stall <= dp2reg_rdma_stall + 32'd1;
    end
  end

endmodule

// File: tb/tb_nv_nvdla_sdp_rdma_ig_cdt.sv
// Directed bench for the SDP RDMA ingress engine. Instance u_a uses the
// default 160-entry latency FIFO; u_b uses a 16-entry one for credit tests.
module tb_nv_nvdla_sdp_rdma_ig_cdt;

  logic        clk, rst;
  logic        op_load_a, op_load_b;
  logic [58:0] base;
  logic [26:0] ls, ss;
  logic [12:0] width, height, surf;
  logic        perf_en, dma_rdy, cq_rdy, pop_a, pop_b;

  logic        vld_a, pvld_a, done_a, busy_a;
  logic [78:0] pd_a;
  logic [15:0] cq_pd_a;
  logic [31:0] stall_a;
  logic        vld_b, pvld_b, done_b, busy_b;
  logic [78:0] pd_b;
  logic [15:0] cq_pd_b;
  logic [31:0] stall_b;

  int errors = 0;
  int checks = 0;

  nv_nvdla_sdp_rdma_ig_cdt u_a (
    .nvdla_core_clk(clk), .nvdla_core_rst(rst), .op_load(op_load_a),
    .reg2dp_base_addr(base), .reg2dp_line_stride(ls), .reg2dp_surface_stride(ss),
    .reg2dp_width(width), .reg2dp_height(height), .reg2dp_surf_num(surf),
    .reg2dp_perf_dma_en(perf_en),
    .dma_rd_req_vld(vld_a), .dma_rd_req_rdy(dma_rdy), .dma_rd_req_pd(pd_a),
    .ig2cq_pvld(pvld_a), .ig2cq_prdy(cq_rdy), .ig2cq_pd(cq_pd_a),
    .cdt_pop(pop_a), .ig_done(done_a), .busy(busy_a), .dp2reg_rdma_stall(stall_a));

  nv_nvdla_sdp_rdma_ig_cdt #(.LAT_DEPTH(16)) u_b (
    .nvdla_core_clk(clk), .nvdla_core_rst(rst), .op_load(op_load_b),
    .reg2dp_base_addr(base), .reg2dp_line_stride(ls), .reg2dp_surface_stride(ss),
    .reg2dp_width(width), .reg2dp_height(height), .reg2dp_surf_num(surf),
    .reg2dp_perf_dma_en(perf_en),
    .dma_rd_req_vld(vld_b), .dma_rd_req_rdy(dma_rdy), .dma_rd_req_pd(pd_b),
    .ig2cq_pvld(pvld_b), .ig2cq_prdy(cq_rdy), .ig2cq_pd(cq_pd_b),
    .cdt_pop(pop_b), .ig_done(done_b), .busy(busy_b), .dp2reg_rdma_stall(stall_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic set_cfg(input logic [58:0] b, input logic [26:0] l, input logic [26:0] s,
                         input logic [12:0] w, input logic [12:0] h, input logic [12:0] n);
    base = b; ls = l; ss = s; width = w; height = h; surf = n;
  endtask

  // Pulse op_load on u_a across one rising edge; returns at the next negedge.
  task automatic load_a();
    op_load_a = 1'b1;
    @(negedge clk);
    op_load_a = 1'b0;
  endtask

  task automatic load_b();
    op_load_b = 1'b1;
    @(negedge clk);
    op_load_b = 1'b0;
  endtask

  // Bounded wait for u_a's done pulse; a timeout is a failed check.
  task automatic wait_done_a();
    int n = 0;
    #1;
    while (done_a !== 1'b1 && n < 60) begin
      @(negedge clk); #1; n++;
    end
    checks++;
    if (done_a !== 1'b1) begin
      errors++; $display("FAIL done_timeout got=%0b exp=1", done_a);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    #1;
    checks++; if (vld_a !== 1'b0)   begin errors++; $display("FAIL rst_vld got=%0b exp=0", vld_a); end
    checks++; if (pvld_a !== 1'b0)  begin errors++; $display("FAIL rst_pvld got=%0b exp=0", pvld_a); end
    checks++; if (pd_a !== 79'd0)   begin errors++; $display("FAIL rst_pd got=%h exp=0", pd_a); end
    checks++; if (cq_pd_a !== 16'd0) begin errors++; $display("FAIL rst_cqpd got=%h exp=0", cq_pd_a); end
    checks++; if (busy_a !== 1'b0 || done_a !== 1'b0) begin errors++; $display("FAIL rst_busy_done got=%0b%0b exp=00", busy_a, done_a); end
    checks++; if (stall_a !== 32'd0) begin errors++; $display("FAIL rst_stall got=%0d exp=0", stall_a); end
    @(negedge clk); rst = 1'b0; @(negedge clk); #1;
    checks++; if (u_a.credit_cnt !== 8'd160) begin errors++; $display("FAIL rst_cdt_a got=%0d exp=160", u_a.credit_cnt); end
    checks++; if (u_b.credit_cnt !== 5'd16)  begin errors++; $display("FAIL rst_cdt_b got=%0d exp=16", u_b.credit_cnt); end
    @(negedge clk);
  endtask

  task automatic test_chunking();
    logic [78:0] exp_pd;
    logic [14:0] sz;
    set_cfg(59'h100, 27'h0, 27'h0, 13'd19, 13'd0, 13'd0);
    load_a();
    for (int i = 0; i < 3; i++) begin
      #1;
      sz = (i == 2) ? 15'd3 : 15'd7;
      exp_pd = {sz, 64'h2000 + 64'(i) * 64'h100};
      checks++; if (vld_a !== 1'b1 || pvld_a !== 1'b1) begin errors++; $display("FAIL chunk_vld%0d got=%0b%0b exp=11", i, vld_a, pvld_a); end
      checks++; if (pd_a !== exp_pd) begin errors++; $display("FAIL chunk_pd%0d got=%h exp=%h", i, pd_a, exp_pd); end
      checks++; if (cq_pd_a !== {(i == 2), sz}) begin errors++; $display("FAIL chunk_cq%0d got=%h exp=%h", i, cq_pd_a, {(i == 2), sz}); end
      @(negedge clk);
    end
    #1;
    checks++; if (done_a !== 1'b1 || busy_a !== 1'b0 || vld_a !== 1'b0) begin errors++; $display("FAIL chunk_done got=d%0b b%0b v%0b exp=d1 b0 v0", done_a, busy_a, vld_a); end
    @(negedge clk); #1;
    checks++; if (done_a !== 1'b0) begin errors++; $display("FAIL chunk_done_pulse got=%0b exp=0", done_a); end
  endtask

  task automatic test_strides();
    logic [63:0] exp_addr [4];
    exp_addr[0] = 64'h0; exp_addr[1] = 64'h200; exp_addr[2] = 64'h2000; exp_addr[3] = 64'h2200;
    set_cfg(59'h0, 27'h10, 27'h100, 13'd3, 13'd1, 13'd1);
    load_a();
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if (pd_a !== {15'd3, exp_addr[i]}) begin errors++; $display("FAIL stride_pd%0d got=%h exp=%h", i, pd_a, {15'd3, exp_addr[i]}); end
      checks++; if (cq_pd_a[15] !== (i == 3)) begin errors++; $display("FAIL stride_last%0d got=%0b exp=%0b", i, cq_pd_a[15], (i == 3)); end
      @(negedge clk);
    end
    #1;
    checks++; if (done_a !== 1'b1) begin errors++; $display("FAIL stride_done got=%0b exp=1", done_a); end
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    set_cfg(59'h100, 27'h0, 27'h0, 13'd19, 13'd0, 13'd0);
    perf_en = 1'b1;
    load_a();
    dma_rdy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++; if (vld_a !== 1'b1 || pd_a !== {15'd7, 64'h2000}) begin errors++; $display("FAIL bp_hold%0d got=v%0b pd=%h exp=v1 pd=%h", i, vld_a, pd_a, {15'd7, 64'h2000}); end
      @(negedge clk);
    end
    dma_rdy = 1'b1; #1;
    checks++; if (stall_a !== 32'd5) begin errors++; $display("FAIL bp_stall got=%0d exp=5", stall_a); end
    wait_done_a();
    checks++; if (stall_a !== 32'd5) begin errors++; $display("FAIL bp_stall_hold got=%0d exp=5", stall_a); end
    perf_en = 1'b0;
    load_a(); #1;
    checks++; if (stall_a !== 32'd0) begin errors++; $display("FAIL bp_clear got=%0d exp=0", stall_a); end
    dma_rdy = 1'b0;
    repeat (5) @(negedge clk);
    dma_rdy = 1'b1; #1;
    checks++; if (stall_a !== 32'd0) begin errors++; $display("FAIL bp_noperf got=%0d exp=0", stall_a); end
    wait_done_a();
  endtask

  // Layers so far consumed 20+16+20+20 atoms of credit with no returns.
  task automatic test_cq_backpressure();
    set_cfg(59'h100, 27'h0, 27'h0, 13'd19, 13'd0, 13'd0);
    cq_rdy = 1'b0;
    load_a(); #1;
    checks++; if (vld_a !== 1'b0 || pvld_a !== 1'b1) begin errors++; $display("FAIL cq_vld got=v%0b p%0b exp=v0 p1", vld_a, pvld_a); end
    repeat (3) @(negedge clk);
    #1;
    checks++; if (u_a.credit_cnt !== 8'd84) begin errors++; $display("FAIL cq_cdt got=%0d exp=84", u_a.credit_cnt); end
    cq_rdy = 1'b1;
    wait_done_a(); #1;
    checks++; if (u_a.credit_cnt !== 8'd64) begin errors++; $display("FAIL cq_cdt_after got=%0d exp=64", u_a.credit_cnt); end
  endtask

  task automatic test_credit_throttle();
    set_cfg(59'h0, 27'h0, 27'h0, 13'd31, 13'd0, 13'd0);
    load_b(); #1;
    checks++; if (vld_b !== 1'b1 || pd_b !== {15'd7, 64'h0}) begin errors++; $display("FAIL thr_req0 got=v%0b pd=%h", vld_b, pd_b); end
    @(negedge clk); #1;
    checks++; if (vld_b !== 1'b1 || pd_b !== {15'd7, 64'h100}) begin errors++; $display("FAIL thr_req1 got=v%0b pd=%h", vld_b, pd_b); end
    repeat (4) @(negedge clk);
    #1;
    checks++; if (vld_b !== 1'b0 || pvld_b !== 1'b0) begin errors++; $display("FAIL thr_block got=v%0b p%0b exp=00", vld_b, pvld_b); end
    for (int i = 0; i < 8; i++) begin
      pop_b = 1'b1; #1;
      checks++; if (vld_b !== 1'b0) begin errors++; $display("FAIL thr_pop%0d got=%0b exp=0", i, vld_b); end
      @(negedge clk);
    end
    pop_b = 1'b0; #1;
    checks++; if (vld_b !== 1'b1 || pd_b !== {15'd7, 64'h200}) begin errors++; $display("FAIL thr_req2 got=v%0b pd=%h", vld_b, pd_b); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_layer();
    set_cfg(59'h40, 27'h0, 27'h0, 13'd19, 13'd0, 13'd0);
    perf_en = 1'b1;
    load_a();
    dma_rdy = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst = 1'b1; #1;
    checks++; if (vld_a !== 1'b0 || pvld_a !== 1'b0 || pd_a !== 79'd0) begin errors++; $display("FAIL mid_out got=v%0b p%0b pd=%h exp=0", vld_a, pvld_a, pd_a); end
    checks++; if (busy_a !== 1'b0 || busy_b !== 1'b0 || stall_a !== 32'd0) begin errors++; $display("FAIL mid_busy got=%0b%0b stall=%0d exp=0", busy_a, busy_b, stall_a); end
    @(negedge clk);
    rst = 1'b0; dma_rdy = 1'b1; perf_en = 1'b0;
    @(negedge clk); #1;
    checks++; if (u_a.credit_cnt !== 8'd160 || u_b.credit_cnt !== 5'd16) begin errors++; $display("FAIL mid_cdt got=%0d,%0d exp=160,16", u_a.credit_cnt, u_b.credit_cnt); end
    set_cfg(59'h100, 27'h0, 27'h0, 13'd19, 13'd0, 13'd0);
    load_a(); #1;
    checks++; if (vld_a !== 1'b1 || pd_a !== {15'd7, 64'h2000}) begin errors++; $display("FAIL mid_restart got=v%0b pd=%h", vld_a, pd_a); end
    wait_done_a();
  endtask

  // Three size-3 fires leave 4 credits; the fourth fires together with a pop.
  task automatic test_pop_fire();
    set_cfg(59'h0, 27'h4, 27'h0, 13'd3, 13'd3, 13'd0);
    load_b();
    repeat (3) @(negedge clk);
    #1;
    checks++; if (u_b.credit_cnt !== 5'd4 || vld_b !== 1'b1) begin errors++; $display("FAIL pf_pre got=%0d v%0b exp=4 v1", u_b.credit_cnt, vld_b); end
    checks++; if (cq_pd_b !== {1'b1, 15'd3}) begin errors++; $display("FAIL pf_last got=%h exp=%h", cq_pd_b, {1'b1, 15'd3}); end
    pop_b = 1'b1;
    @(negedge clk);
    pop_b = 1'b0; #1;
    checks++; if (u_b.credit_cnt !== 5'd1) begin errors++; $display("FAIL pf_cdt got=%0d exp=1", u_b.credit_cnt); end
    checks++; if (done_b !== 1'b1) begin errors++; $display("FAIL pf_done got=%0b exp=1", done_b); end
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; op_load_a = 1'b0; op_load_b = 1'b0;
    perf_en = 1'b0; dma_rdy = 1'b1; cq_rdy = 1'b1; pop_a = 1'b0; pop_b = 1'b0;
    set_cfg(59'h0, 27'h0, 27'h0, 13'd0, 13'd0, 13'd0);
    repeat (2) @(negedge clk);
    test_reset();
    test_chunking();
    test_strides();
    test_backpressure();
    test_cq_backpressure();
    test_credit_throttle();
    test_reset_mid_layer();
    test_pop_fire();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/nv_nvdla_sdp_rdma_ig_cdt.md
# nv_nvdla_sdp_rdma_ig_cdt

Parametrised SDP read-DMA ingress engine with credit-based flow control: the next generation of the per-operand (B/N/E) RDMA request side. It walks a 3-D surface (atoms per line × lines × surfaces) using line and surface strides, and splits lines into bursts of at most BURST_MAX atoms. Each burst is issued as a DMA read request, with a matching context entry pushed to the context queue in the same cycle. Issue is gated by a credit counter that mirrors free latency-FIFO entries.

## Interface
Parameters:
- AW, 64, DMA byte-address width
- AM_AW, 5, log2 of atom bytes (32 B atom)
- LAT_DEPTH, 160, latency-FIFO entries (= initial credits, one per atom)
- BURST_MAX, 8, maximum atoms per request (power of 2, 1..32)

Ports:
- nvdla_core_clk  in  1  clock
- nvdla_core_rst  in  1  reset, asynchronous, active-high
- op_load  in  1  one-cycle layer start
- reg2dp_base_addr  in  AW-AM_AW  surface base, atom units
- reg2dp_line_stride  in  32-AM_AW  atom units
- reg2dp_surface_stride  in  32-AM_AW  atom units
- reg2dp_width  in  13  atoms per line minus 1
- reg2dp_height  in  13  lines per surface minus 1
- reg2dp_surf_num  in  13  surfaces minus 1
- reg2dp_perf_dma_en  in  1  stall counter enable
- dma_rd_req_vld  out  1  request valid
- dma_rd_req_rdy  in  1  request ready
- dma_rd_req_pd  out  AW+15  {size[14:0] atoms−1, addr[AW-1:0] bytes}
- ig2cq_pvld  out  1  context valid
- ig2cq_prdy  in  1  context ready
- ig2cq_pd  out  16  {layer_last, size[14:0]}
- cdt_pop  in  1  one latency-FIFO entry freed
- ig_done  out  1  pulse: last request of layer accepted
- busy  out  1  layer in progress
- dp2reg_rdma_stall  out  32  stall cycle count

## Operation
- States: IDLE, RUN.
  - IDLE→RUN on op_load, which latches all reg2dp_* fields and clears the x/y/s counters.
  - op_load while in RUN is ignored.
- Chunking:
  - size = min(BURST_MAX, remaining atoms in line) − 1.
  - No chunk spans two lines.
- Address:
  - addr = (line_addr + x) << AM_AW, low AM_AW bits always 0.
  - End of line: line_addr += line_stride.
  - End of surface: surf_addr += surface_stride, and line_addr = new surf_addr.
  - All sums wrap modulo 2^(AW-AM_AW).
- Fire = dma_rd_req_vld & dma_rd_req_rdy, which equals ig2cq_pvld & ig2cq_prdy by construction.
- Credit check: credit_ok = credit_cnt ≥ size+1.
- Handshake equations:
  - dma_rd_req_vld = RUN & credit_ok & ig2cq_prdy.
  - ig2cq_pvld = RUN & credit_ok & dma_rd_req_rdy.
- Credit counter:
  - Width clog2(LAT_DEPTH+1); reset value LAT_DEPTH.
  - next = cnt − (fire ? size+1 : 0) + cdt_pop. Simultaneous fire and pop are both applied.
  - Not reset by op_load, because data from the previous layer may still be outstanding.
  - Overflow above LAT_DEPTH is a protocol error, flagged by an assertion; the counter saturates.
- layer_last = 1 on the final chunk (x, y, s all at their maximum).
- ig_done: fire of the final chunk → RUN→IDLE on the same edge, and ig_done is a registered pulse the following cycle.
- Stall counter:
  - Increments when perf_dma_en & dma_rd_req_vld & !dma_rd_req_rdy.
  - Saturates at 0xFFFF_FFFF; cleared by op_load.
- Payload outputs hold stable while valid is high and ready is low.

## Timing
- Reset values: dma_rd_req_vld=0, ig2cq_pvld=0, pd=0, ig_done=0, busy=0, stall=0, credits=LAT_DEPTH, state IDLE.
- Reset mid-RUN aborts immediately; no partial request is issued.
- First request valid 1 cycle after op_load, if credits and ready allow.
- Sustained throughput is 1 request/cycle when both readys are high and credits suffice.
- Credit returned by cdt_pop at edge N is usable for the issue decision at cycle N+1.
- busy = RUN; it deasserts in the cycle ig_done is high.

## Test plan
- Chunking: width=19, height=0, surf=0, BURST_MAX=8, base=0x100 → sizes 7, 7, 3 at byte addrs 0x2000, 0x2100, 0x2200; layer_last on the third only; ig_done one cycle after the third fire.
- Credit throttle: LAT_DEPTH=16, width=31, no cdt_pop → two size-7 requests, then vld stays 0. Eight cdt_pop pulses → third request is valid the cycle after the 8th pop.
- Strides: width=3, height=1, surf=1, base=0, line_stride=0x10, surface_stride=0x100 → addrs 0x0, 0x200, 0x2000, 0x2200, all size 3.
- Backpressure: dma_rd_req_rdy low 5 cycles with perf_dma_en=1 → stall=5, pd stable; with perf_dma_en=0 → stall=0. A second op_load clears it.
- Simultaneous cdt_pop and fire of size 3 with credits=4 → credits=1 next cycle. ig2cq_prdy low → no DMA request and no credit change.
- Reset asserted mid-layer → all outputs 0 asynchronously, credits=LAT_DEPTH after release; a new op_load restarts at base.
